// File: rtl/dsc_op_sequencer.sv
// Host-side initiator for the stochastic-computing core: accept operands, clear, run, report.
// Optional DSC_SEQ_STATS_EN adds op/truncation counters on stat_ops and stat_trunc.
module dsc_op_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned WXIP1      = 17
) (
  input  logic                             gclk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] op_data,
  input  logic [WXIP1-1:0]                 cyc_limit,
  output logic                             core_rst,
  output logic                             core_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data,
  input  logic [WXIP1-1:0]                 core_data_out,
  input  logic                             core_op_finished,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [WXIP1-1:0]                 res_data,
  output logic [WXIP1-1:0]                 res_cycles,
  output logic                             res_truncated,
  output logic                             res_overflow
`ifdef DSC_SEQ_STATS_EN
  ,
  output logic [31:0]                      stat_ops,
  output logic [31:0]                      stat_trunc
`endif
);

  localparam int unsigned OpW = NUM_INPUTS * DATA_WIDTH;
  localparam logic [WXIP1-1:0] CntOne = WXIP1'(1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [WXIP1-1:0] cnt_q, cnt_d;
  logic [WXIP1-1:0] lim_q, lim_d;
  logic [WXIP1-1:0] cnt_inc;
  logic [OpW-1:0]   core_data_q, core_data_d;
  logic [WXIP1-1:0] res_data_q, res_data_d;
  logic [WXIP1-1:0] res_cycles_q, res_cycles_d;
  logic             res_trunc_q, res_trunc_d;
  logic             res_ovf_q, res_ovf_d;
  logic             op_ready_q, core_rst_q, core_en_q, res_valid_q;
  logic             hit_fin, hit_bud, hit_ovf;

  assign cnt_inc = cnt_q + CntOne;
  assign hit_fin = core_op_finished;
  assign hit_bud = (lim_q != '0) && (cnt_inc == lim_q);
  assign hit_ovf = &cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lim_d        = lim_q;
    core_data_d  = core_data_q;
    res_data_d   = res_data_q;
    res_cycles_d = res_cycles_q;
    res_trunc_d  = res_trunc_q;
    res_ovf_d    = res_ovf_q;
    case (state_q)
      StIdle: begin
        if (op_valid && op_ready_q) begin
          core_data_d = op_data;
          lim_d       = cyc_limit;
          state_d     = StClear;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (hit_fin || hit_bud || hit_ovf) begin
          // Finished outranks budget, budget outranks overflow.
          res_data_d   = core_data_out;
          res_cycles_d = hit_ovf ? '1 : cnt_inc;
          res_trunc_d  = hit_bud && !hit_fin;
          res_ovf_d    = hit_ovf && !hit_fin;
          state_d      = StHold;
        end
      end
      StHold: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lim_q        <= '0;
      core_data_q  <= '0;
      res_data_q   <= '0;
      res_cycles_q <= '0;
      res_trunc_q  <= 1'b0;
      res_ovf_q    <= 1'b0;
      op_ready_q   <= 1'b1;
      core_rst_q   <= 1'b1;
      core_en_q    <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lim_q        <= lim_d;
      core_data_q  <= core_data_d;
      res_data_q   <= res_data_d;
      res_cycles_q <= res_cycles_d;
      res_trunc_q  <= res_trunc_d;
      res_ovf_q    <= res_ovf_d;
      // Strobes are registered from the next state so they line up with it.
      op_ready_q   <= (state_d == StIdle);
      core_rst_q   <= (state_d == StClear);
      core_en_q    <= (state_d == StRun);
      res_valid_q  <= (state_d == StHold);
    end
  end

  assign op_ready      = op_ready_q;
  assign core_rst      = core_rst_q;
  assign core_en       = core_en_q;
  assign core_data     = core_data_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_cycles    = res_cycles_q;
  assign res_truncated = res_trunc_q;
  assign res_overflow  = res_ovf_q;

`ifdef DSC_SEQ_STATS_EN
  logic [31:0] stat_ops_q, stat_trunc_q;

  always_ff @(posedge gclk) begin
    if (rst) begin
      stat_ops_q   <= '0;
      stat_trunc_q <= '0;
    end else if (res_valid_q && res_ready) begin
      stat_ops_q <= stat_ops_q + 32'd1;
      if (res_trunc_q) stat_trunc_q <= stat_trunc_q + 32'd1;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_trunc = stat_trunc_q;
`endif

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Self-checking bench for dsc_op_sequencer: behavioural core model plus a min-of-stop-points
// reference for result, cycle count and status flags.
module tb_dsc_op_sequencer;

  localparam int DW  = 8;
  localparam int NI  = 2;
  localparam int W   = 8;  // narrow result width keeps the overflow case short
  localparam int OPW = DW * NI;

  logic           gclk = 1'b0;
  logic           rst;
  logic           op_valid;
  logic           op_ready;
  logic [OPW-1:0] op_data;
  logic [W-1:0]   cyc_limit;
  logic           core_rst;
  logic           core_en;
  logic [OPW-1:0] core_data;
  logic [W-1:0]   core_data_out;
  logic           core_op_finished;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [W-1:0]   res_cycles;
  logic           res_truncated;
  logic           res_overflow;
`ifdef DSC_SEQ_STATS_EN
  logic [31:0]    stat_ops;
  logic [31:0]    stat_trunc;
`endif

  int tests = 0;
  int fails = 0;

  dsc_op_sequencer #(
    .DATA_WIDTH(DW),
    .NUM_INPUTS(NI),
    .WXIP1     (W)
  ) dut (
    .gclk            (gclk),
    .rst             (rst),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_data         (op_data),
    .cyc_limit       (cyc_limit),
    .core_rst        (core_rst),
    .core_en         (core_en),
    .core_data       (core_data),
    .core_data_out   (core_data_out),
    .core_op_finished(core_op_finished),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_cycles      (res_cycles),
    .res_truncated   (res_truncated),
    .res_overflow    (res_overflow)
`ifdef DSC_SEQ_STATS_EN
    ,
    .stat_ops        (stat_ops),
    .stat_trunc      (stat_trunc)
`endif
  );

  always #5 gclk = ~gclk;

  // Core model: counts enabled cycles since its reset; finishes on cycle fin_at (0 = never),
  // output on enabled cycle n is out_base + n.
  int           run_cnt = 0;
  int           fin_at  = 0;
  logic [W-1:0] out_base = '0;

  always @(posedge gclk) begin
    if (core_rst) run_cnt <= 0;
    else if (core_en) run_cnt <= run_cnt + 1;
  end

  assign core_op_finished = core_en && (fin_at != 0) && (run_cnt + 1 == fin_at);
  assign core_data_out    = out_base + W'(run_cnt + 1);

  typedef struct {
    int             lat;
    logic [W-1:0]   d;
    logic [W-1:0]   cy;
    logic           tr;
    logic           ov;
    logic           clr_rst;
    logic           clr_en;
    logic [OPW-1:0] cd;
    logic           rdy_in;
  } obs_t;

  // Run stops at the earliest of: finish cycle, budget, counter saturation (cycle 2^W).
  function automatic void model(input int lim, input int fin, input logic [W-1:0] base,
                                output int k, output logic [W-1:0] d, output logic [W-1:0] cy,
                                output logic tr, output logic ov);
    int kf, kl, ko;
    kf = (fin != 0) ? fin : 32'h7fffffff;
    kl = (lim != 0) ? lim : 32'h7fffffff;
    ko = 1 << W;
    k  = kf;
    if (kl < k) k = kl;
    if (ko < k) k = ko;
    d  = base + W'(k);
    cy = (k >= ko) ? {W{1'b1}} : W'(k);
    tr = (k == kl) && (k != kf);
    ov = (k == ko) && (k != kf);
  endfunction

  // Starts and ends just after a falling edge; leaves the result pending in HOLD.
  task automatic run_op(input logic [OPW-1:0] op, input logic [W-1:0] lim, input int fin,
                        input logic [W-1:0] base, output obs_t o);
    int n;
    o.lat    = -1;
    fin_at   = fin;
    out_base = base;
    op_valid = 1'b1;
    op_data  = op;
    cyc_limit = lim;
    o.rdy_in = op_ready;
    @(posedge gclk);
    @(negedge gclk);
    op_valid  = 1'b0;
    op_data   = OPW'($urandom);
    cyc_limit = W'($urandom);
    n = 1;
    o.clr_rst = core_rst;
    o.clr_en  = core_en;
    o.cd      = core_data;
    while (!res_valid && n < 600) begin
      @(negedge gclk);
      n++;
    end
    if (res_valid) o.lat = n;
    o.d  = res_data;
    o.cy = res_cycles;
    o.tr = res_truncated;
    o.ov = res_overflow;
  endtask

  task automatic release_res(output logic rdy_after);
    res_ready = 1'b1;
    @(posedge gclk);
    @(negedge gclk);
    res_ready = 1'b0;
    rdy_after = op_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0; op_data = '0; cyc_limit = '0;
    repeat (2) @(negedge gclk);
    tests++;
    if (op_ready !== 1'b1 || core_rst !== 1'b1 || core_en !== 1'b0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got rdy=%b crst=%b en=%b rv=%b want 1 1 0 0",
               op_ready, core_rst, core_en, res_valid);
    end
    tests++;
    if (core_data !== '0 || res_data !== '0 || res_cycles !== '0 ||
        res_truncated !== 1'b0 || res_overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_data: got cd=%h rd=%h rc=%h tr=%b ov=%b want all 0",
               core_data, res_data, res_cycles, res_truncated, res_overflow);
    end
`ifdef DSC_SEQ_STATS_EN
    tests++;
    if (stat_ops !== 32'd0 || stat_trunc !== 32'd0) begin
      fails++;
      $display("FAIL reset_stats: got %0d %0d want 0 0", stat_ops, stat_trunc);
    end
`endif
    rst = 1'b0;
    @(negedge gclk);
    tests++;
    if (core_rst !== 1'b0 || op_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: got crst=%b rdy=%b want 0 1", core_rst, op_ready);
    end
  endtask

  task automatic test_finished;
    obs_t o;
    logic ra;
    run_op({8'd5, 8'd3}, '0, 15, '0, o);
    tests++;
    if (o.lat !== 17) begin fails++; $display("FAIL fin_latency: got %0d want 17", o.lat); end
    tests++;
    if (o.clr_rst !== 1'b1 || o.clr_en !== 1'b0 || o.cd !== {8'd5, 8'd3}) begin
      fails++;
      $display("FAIL fin_clear: got crst=%b en=%b cd=%h want 1 0 0503", o.clr_rst, o.clr_en, o.cd);
    end
    tests++;
    if (o.d !== 8'd15 || o.cy !== 8'd15 || o.tr !== 1'b0 || o.ov !== 1'b0) begin
      fails++;
      $display("FAIL fin_result: got d=%0d cy=%0d tr=%b ov=%b want 15 15 0 0",
               o.d, o.cy, o.tr, o.ov);
    end
    release_res(ra);
    tests++;
    if (ra !== 1'b1) begin fails++; $display("FAIL fin_ready_after: got %b want 1", ra); end
  endtask

  task automatic test_budget;
    obs_t o;
    logic ra;
    run_op(OPW'($urandom), 8'd4, 0, 8'hFE, o);
    tests++;
    if (o.lat !== 6 || o.d !== 8'd2 || o.cy !== 8'd4 || o.tr !== 1'b1 || o.ov !== 1'b0) begin
      fails++;
      $display("FAIL budget: got lat=%0d d=%0d cy=%0d tr=%b ov=%b want 6 2 4 1 0",
               o.lat, o.d, o.cy, o.tr, o.ov);
    end
    release_res(ra);
  endtask

  task automatic test_simultaneous;
    obs_t o;
    logic ra;
    run_op(OPW'($urandom), 8'd6, 6, '0, o);
    tests++;
    if (o.cy !== 8'd6 || o.tr !== 1'b0 || o.ov !== 1'b0) begin
      fails++;
      $display("FAIL simultaneous: got cy=%0d tr=%b ov=%b want 6 0 0", o.cy, o.tr, o.ov);
    end
    release_res(ra);
  endtask

  task automatic test_overflow;
    obs_t o;
    logic ra;
    run_op(OPW'($urandom), '0, 0, 8'h11, o);
    tests++;
    if (o.lat !== 258 || o.cy !== 8'hFF || o.tr !== 1'b0 || o.ov !== 1'b1 || o.d !== 8'h11) begin
      fails++;
      $display("FAIL overflow: got lat=%0d cy=%h tr=%b ov=%b d=%h want 258 ff 0 1 11",
               o.lat, o.cy, o.tr, o.ov, o.d);
    end
    release_res(ra);
    // Finishing on the saturating cycle clears the overflow flag.
    run_op(OPW'($urandom), '0, 256, 8'h20, o);
    tests++;
    if (o.lat !== 258 || o.cy !== 8'hFF || o.ov !== 1'b0 || o.tr !== 1'b0) begin
      fails++;
      $display("FAIL overflow_fin: got lat=%0d cy=%h ov=%b tr=%b want 258 ff 0 0",
               o.lat, o.cy, o.ov, o.tr);
    end
    release_res(ra);
  endtask

  task automatic test_back_pressure;
    obs_t o;
    logic [OPW-1:0] nxt;
    int n;
    run_op(OPW'($urandom), '0, 5, W'($urandom), o);
    nxt = 16'hA5C3;
    op_valid = 1'b1;
    op_data  = nxt;
    cyc_limit = 8'd2;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (res_valid !== 1'b1 || res_data !== o.d || res_cycles !== 8'd5 ||
          op_ready !== 1'b0 || core_en !== 1'b0) begin
        fails++;
        $display("FAIL bp_stable[%0d]: got rv=%b d=%h cy=%0d rdy=%b en=%b want 1 %h 5 0 0",
                 i, res_valid, res_data, res_cycles, op_ready, core_en, o.d);
      end
      @(negedge gclk);
    end
    res_ready = 1'b1;
    @(posedge gclk);
    @(negedge gclk);
    res_ready = 1'b0;
    tests++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: got rdy=%b rv=%b want 1 0", op_ready, res_valid);
    end
    fin_at = 0;
    @(negedge gclk);
    op_valid = 1'b0;
    tests++;
    if (core_rst !== 1'b1 || core_data !== nxt) begin
      fails++;
      $display("FAIL bp_next_accept: got crst=%b cd=%h want 1 %h", core_rst, core_data, nxt);
    end
    n = 0;
    while (!res_valid && n < 50) begin @(negedge gclk); n++; end
    tests++;
    if (res_cycles !== 8'd2 || res_truncated !== 1'b1) begin
      fails++;
      $display("FAIL bp_next_result: got cy=%0d tr=%b want 2 1", res_cycles, res_truncated);
    end
    res_ready = 1'b1;
    @(posedge gclk);
    @(negedge gclk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    fin_at = 0;
    op_valid = 1'b1;
    op_data = OPW'($urandom);
    cyc_limit = '0;
    @(posedge gclk);
    @(negedge gclk);
    op_valid = 1'b0;
    repeat (3) @(negedge gclk);
    tests++;
    if (core_en !== 1'b1) begin fails++; $display("FAIL mid_run_active: got en=%b want 1", core_en); end
    rst = 1'b1;
    @(negedge gclk);
    tests++;
    if (core_rst !== 1'b1 || core_en !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b1 ||
        core_data !== '0) begin
      fails++;
      $display("FAIL mid_run_reset: got crst=%b en=%b rv=%b rdy=%b cd=%h want 1 0 0 1 0",
               core_rst, core_en, res_valid, op_ready, core_data);
    end
    rst = 1'b0;
    @(negedge gclk);
    tests++;
    if (op_ready !== 1'b1 || core_rst !== 1'b0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_run_release: got rdy=%b crst=%b rv=%b want 1 0 0",
               op_ready, core_rst, res_valid);
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic ra;
    int lim, fin, k;
    logic [OPW-1:0] op;
    logic [W-1:0] base, ed, ecy;
    logic etr, eov;
    for (int i = 0; i < 25; i++) begin
      lim  = $urandom_range(0, 40);
      fin  = $urandom_range(0, 40);
      op   = OPW'($urandom);
      base = W'($urandom);
      model(lim, fin, base, k, ed, ecy, etr, eov);
      run_op(op, W'(lim), fin, base, o);
      tests++;
      if (o.lat !== k + 2 || o.d !== ed || o.cy !== ecy || o.tr !== etr || o.ov !== eov ||
          o.cd !== op || o.rdy_in !== 1'b1) begin
        fails++;
        $display("FAIL rand[%0d] lim=%0d fin=%0d: got lat=%0d d=%h cy=%0d tr=%b ov=%b cd=%h rdy=%b want %0d %h %0d %b %b %h 1",
                 i, lim, fin, o.lat, o.d, o.cy, o.tr, o.ov, o.cd, o.rdy_in,
                 k + 2, ed, ecy, etr, eov, op);
      end
      repeat ($urandom_range(0, 3)) @(negedge gclk);
      release_res(ra);
    end
  endtask

  task automatic test_stats;
`ifdef DSC_SEQ_STATS_EN
    obs_t o;
    logic ra;
    rst = 1'b1;
    @(negedge gclk);
    rst = 1'b0;
    @(negedge gclk);
    run_op(OPW'($urandom), '0, 5, '0, o);
    release_res(ra);
    run_op(OPW'($urandom), 8'd3, 0, '0, o);
    release_res(ra);
    run_op(OPW'($urandom), 8'd7, 7, '0, o);
    release_res(ra);
    tests++;
    if (stat_ops !== 32'd3 || stat_trunc !== 32'd1) begin
      fails++;
      $display("FAIL stats: got ops=%0d trunc=%0d want 3 1", stat_ops, stat_trunc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_finished();
    test_budget();
    test_simultaneous();
    test_overflow();
    test_back_pressure();
    test_reset_mid_run();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsc_op_sequencer.md
# dsc_op_sequencer

Synthesizable host-side initiator for the deterministic stochastic-computing `core`. It accepts an operand vector over a valid/ready handshake and clears the core, then enables it. It counts run cycles and stops on `op_finished` or a programmable cycle budget, then returns the binary result, the cycle count and status over a second valid/ready handshake. It replaces bench-driven rst/en sequencing so the core can run under on-chip control and in power/area sweeps.

## Interface
- `DATA_WIDTH`, 8: width of one operand.
- `NUM_INPUTS`, 2: operand count; the operand bus is `NUM_INPUTS*DATA_WIDTH` wide, and operand i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `WXIP1`, 17: width of the core result, cycle counter and budget.
- `gclk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `op_valid`  in  1  operand vector offered.
- `op_ready`  out  1  sequencer can accept an operand vector.
- `op_data`  in  NUM_INPUTS*DATA_WIDTH  operand vector.
- `cyc_limit`  in  WXIP1  cycle budget; 0 means run to `op_finished`.
- `core_rst`  out  1  reset to the core.
- `core_en`  out  1  enable to the core.
- `core_data`  out  NUM_INPUTS*DATA_WIDTH  latched operands to the core.
- `core_data_out`  in  WXIP1  core binary result.
- `core_op_finished`  in  1  core completion flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  WXIP1  captured core result.
- `res_cycles`  out  WXIP1  number of RUN cycles used.
- `res_truncated`  out  1  run stopped by the budget, not by `op_finished`.
- `res_overflow`  out  1  run stopped because the cycle counter saturated.

## Operation
- The FSM has four states: IDLE, CLEAR, RUN and HOLD.
- **IDLE**
  - `op_ready`=1.
  - On `op_valid && op_ready`, the block latches `op_data` into `core_data` and `cyc_limit` into `lim_q`, then moves to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `core_rst`=1, `core_en`=0, `cnt`<=0.
  - Moves to RUN.
- **RUN**
  - `core_rst`=0, `core_en`=1, `cnt`<=`cnt`+1 every cycle.
  - The run terminates in the RUN cycle where any of these holds:
    - (a) `core_op_finished`=1;
    - (b) `lim_q`!=0 and `cnt`+1==`lim_q`;
    - (c) `cnt`==all-ones.
  - On termination, the block captures:
    - `res_data`<=`core_data_out`;
    - `res_cycles`<=`cnt`+1, or all-ones in case (c);
    - `res_truncated`<=(b)&&!(a);
    - `res_overflow`<=(c)&&!(a).
  - It then moves to HOLD.
- **HOLD**
  - `res_valid`=1 and `core_en`=0. `core_rst` stays 0, so the core output is frozen.
  - The `res_*` outputs are stable until `res_valid && res_ready`, then the block moves to IDLE.
- Priority: finished beats budget, and budget beats overflow. When (a) and (b) hit in the same cycle, `res_truncated`=0.
- `cyc_limit` and `op_data` are ignored outside the IDLE accept cycle.
- `op_ready`=0 in CLEAR, RUN and HOLD. `op_valid` is ignored there and there is no queueing.

## Timing
- Reset values: IDLE, `op_ready`=1, `core_rst`=1, `core_en`=0, `core_data`=0, `res_valid`=0, `res_data`=0, `res_cycles`=0, `res_truncated`=0, `res_overflow`=0.
- `core_rst` is high while `rst`=1 and in CLEAR. It goes low on the first IDLE cycle after reset.
- For an accept at edge T:
  - CLEAR occupies T+1;
  - RUN starts at T+2;
  - for termination on RUN cycle k (k=1..), `res_valid` rises at T+2+k.
- The result handshake at edge H returns the block to IDLE, so `op_ready`=1 at H+1. The minimum accept-to-accept interval is k+3 cycles.
- `rst`=1 in any state: on the next edge the block goes to IDLE with all outputs at reset values. Any in-flight result is discarded.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `DSC_SEQ_STATS_EN` defined: adds ports `stat_ops` out 32 and `stat_trunc` out 32. Both reset to 0.
  - `stat_ops` increments on each result handshake.
  - `stat_trunc` increments on each result handshake with `res_truncated`=1.
  - Both wrap at 2^32.
- `DSC_SEQ_STATS_EN` undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Finished case: operands (3,5), `cyc_limit`=0, core model finishes on RUN cycle 15 with output 15 → `res_data`=15, `res_cycles`=15, `res_truncated`=0, `res_valid` at accept+17.
- Budget case: `cyc_limit`=4, core never finishes, `core_data_out`=2 on RUN cycle 4 → `res_data`=2, `res_cycles`=4, `res_truncated`=1.
- Simultaneous case: `cyc_limit`=6 and `core_op_finished` on RUN cycle 6 → `res_cycles`=6, `res_truncated`=0.
- Back-pressure: `res_ready`=0 for 10 cycles while `op_valid`=1 → `res_*` stable, `op_ready`=0, `core_en`=0; the next op is accepted only after the handshake.
- Reset mid-RUN: `rst` pulsed on RUN cycle 3 → next cycle `core_rst`=1, `core_en`=0, `res_valid`=0; after release `op_ready`=1.
- With `DSC_SEQ_STATS_EN`: three ops, one budget-truncated → `stat_ops`=3, `stat_trunc`=1.
